// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch front end.
// The queue entry pairs a fetch address with the instruction word read from it.
package fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries between the instruction ROM and decode.
// A flush on the same edge as a push wins, so squashed fetches never land in the queue.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           din,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem_q [DEPTH];
   fetch_entry_t    mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push;
   logic            do_pop;

   // A push into a full queue is only accepted when the head leaves on the same edge.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Decoupled fetch stage: synchronous instruction ROM, credit-based issue into a prefetch
// FIFO, valid/ready handshake to decode, and queue squash on branch/jump redirects.
module fetch_prefetch_queue #(
   parameter int                             XLEN     = 32,
   parameter int                             DEPTH    = 4,
   parameter int                             IMEM_AW  = 8,
   parameter logic [XLEN-1:0]                RESET_PC = '0,
   parameter logic [(2**IMEM_AW)*XLEN-1:0]   ROM_INIT = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   branch,
   input  logic [XLEN-1:0]        branch_addr,
   input  logic                   jump,
   input  logic [XLEN-1:0]        jump_addr,
   input  logic                   id_ready,
   output logic                   if_valid,
   output logic [XLEN-1:0]        PC,
   output logic [XLEN-1:0]        NPC,
   output logic [XLEN-1:0]        IR,
   output logic [$clog2(DEPTH):0] count
);

   import fetch_pkg::*;

   localparam int CW        = $clog2(DEPTH) + 1;
   localparam int ROM_WORDS = 2 ** IMEM_AW;

   logic [XLEN-1:0]    rom [ROM_WORDS];

   logic [XLEN-1:0]    fpc_q, fpc_d;
   logic               inflight_q, inflight_d;
   logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;
   logic [XLEN-1:0]    rom_data_q, rom_data_d;

   logic               redirect;
   logic [XLEN-1:0]    target;
   logic               deq;
   logic               issue;
   logic [CW:0]        credit_used;
   logic [IMEM_AW-1:0] rom_idx;
   logic [CW-1:0]      fifo_count;
   fetch_entry_t       push_entry;
   fetch_entry_t       head;

   for (genvar i = 0; i < ROM_WORDS; i++) begin : g_rom
      assign rom[i] = ROM_INIT[i*XLEN +: XLEN];
   end

   // Branch comes from an older instruction than the jump, so it takes precedence.
   always_comb begin
      redirect = branch || jump;
      target   = branch ? branch_addr : jump_addr;
      target   = {target[XLEN-1:2], 2'b00};
   end

   // Credits count queued plus in-flight entries, less the one leaving this cycle.
   always_comb begin
      deq         = if_valid && id_ready;
      credit_used = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(deq);
      issue       = !redirect && (credit_used < (CW+1)'(DEPTH));
      rom_idx     = fpc_q[IMEM_AW+1:2];
   end

   always_comb begin
      fpc_d         = fpc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      rom_data_d    = rom_data_q;
      if (redirect) begin
         fpc_d = target;
      end else if (issue) begin
         fpc_d         = fpc_q + XLEN'(INSTR_BYTES);
         inflight_d    = 1'b1;
         inflight_pc_d = fpc_q;
         rom_data_d    = rom[rom_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q         <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rom_data_q    <= NOP_INSTR;
      end else begin
         fpc_q         <= fpc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rom_data_q    <= rom_data_d;
      end
   end

   always_comb begin
      push_entry.pc    = inflight_pc_q;
      push_entry.instr = rom_data_q;
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight_q),
      .pop   (deq),
      .flush (redirect),
      .din   (push_entry),
      .count (fifo_count),
      .head  (head)
   );

   // Outputs come straight from the registered head and are zeroed while empty.
   always_comb begin
      if_valid = (fifo_count != '0);
      count    = fifo_count;
      PC       = '0;
      NPC      = '0;
      IR       = NOP_INSTR;
      if (if_valid) begin
         PC  = head.pc;
         NPC = head.pc + XLEN'(INSTR_BYTES);
         IR  = head.instr;
      end
   end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Parametrised instruction-fetch front end for the pipelined GCD MIPS core. It replaces the single-slot fetch stage with a decoupled unit: an internal synchronous instruction ROM, a prefetch FIFO of configurable depth, and a valid/ready handshake into decode. Fetch runs ahead of a stalled decode stage, and the whole queue is squashed on branch or jump redirects. It sits between the core's redirect sources (EX/MEM branch, ID jump) and the decode stage.

## Interface

Parameters:
- `XLEN`, default 32: PC and instruction width.
- `DEPTH`, default 4: FIFO entries, power of two, at least 2.
- `IMEM_AW`, default 8: ROM word-address bits, giving 2^IMEM_AW words.
- `RESET_PC`, default 0: first fetch address.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `branch` in 1: branch redirect request.
- `branch_addr` in XLEN: branch target.
- `jump` in 1: jump redirect request.
- `jump_addr` in XLEN: jump target.
- `id_ready` in 1: decode accepts the head entry this cycle.
- `if_valid` out 1: head entry valid.
- `PC` out XLEN: byte address of the head instruction.
- `NPC` out XLEN: `PC`+4 of the head instruction.
- `IR` out XLEN: head instruction word.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation

- State:
  - `fpc` is the next fetch address.
  - `inflight` is 1 when a ROM read was issued last cycle.
  - The FIFO holds {pc, instruction} entries.
- Issue: when `count + inflight - deq < DEPTH` and there is no redirect, the unit does three things:
  - reads ROM at `fpc[IMEM_AW+1:2]`;
  - sets `inflight` to 1;
  - updates `fpc` to `fpc + 4`.
  Here `deq` = `if_valid && id_ready`.
- Return: when `inflight` = 1, the ROM data and its pc are enqueued on the next edge.
- Dequeue: `if_valid && id_ready` pops the head. Enqueue and dequeue in the same cycle are legal at any occupancy, including full.
- Redirect:
  - `branch` has priority over `jump`, since the branch is the older instruction. The target is the selected address with bits [1:0] forced to 0.
  - On the redirect edge: the FIFO is emptied, `inflight` is cleared (any in-flight data is discarded), and `fpc` takes the target.
  - No issue occurs on the redirect edge.
  - A dequeue asserted in the redirect cycle counts as accepted; discarding that instruction is decode's responsibility.
- Wrap-around:
  - `fpc` wraps modulo 2^XLEN.
  - ROM indexing wraps modulo 2^IMEM_AW words.
  - FIFO pointers wrap modulo `DEPTH`.
- ROM contents are loaded at elaboration. Unwritten words read as 0 (NOP).

## Timing

- Reset values:
  - `fpc` = `RESET_PC`; `inflight` = 0; `count` = 0; `if_valid` = 0.
  - `PC`, `NPC`, `IR` = 0 while the FIFO is empty.
  - Reset asserted mid-operation discards all queued and in-flight fetches on that edge.
- Fetch latency:
  - The first edge with `rst` low issues a fetch; the next edge enqueues it, so `if_valid` rises 2 cycles after reset release.
  - A redirect sampled at edge E gives `if_valid` with the target instruction after edge E+2.
- Throughput: 1 instruction/cycle sustained with `id_ready` held high.
- Outputs are driven from the registered FIFO head, with no combinational path from `id_ready`.
- `if_valid` = (`count` != 0). While empty, `PC`, `NPC`, `IR` are 0.
- Redirects arriving on back-to-back cycles: each one flushes; the last one wins.

## Structure

- Shared package `fetch_pkg`:
  - `XLEN` default;
  - `INSTR_BYTES` = 4;
  - `NOP_INSTR` = 32'h0000_0000;
  - typedef `fetch_entry_t` = {pc, instr}.
- Sub-module `fetch_fifo`:
  - parametrised by `DEPTH`, with payload `fetch_entry_t`;
  - ports push, pop, flush, count, head;
  - flush has priority over push on the same edge.
- The ROM array, `fpc`, the issue/credit logic and the redirect mux stay in the top module.

## Test plan

- **Reset and stream:** ROM[i] = 0x1000+i, `id_ready`=1, release `rst` → `if_valid` rises after the 2nd edge. `PC` = 0, 4, 8, … with `IR` = 0x1000, 0x1001, … on consecutive cycles, and `NPC` = `PC`+4.
- **Backpressure:** `id_ready`=0 for 10 cycles → `count` saturates at `DEPTH`=4 and exactly 4 reads are enqueued. Then raise `id_ready` → PCs 0, 4, 8, 12, 16 in order with no gaps and no duplicates.
- **Branch redirect:** assert `branch` with `branch_addr`=0x40 while the FIFO holds 3 entries and a fetch is in flight → `count`=0 after the edge, and 2 edges later `PC`=0x40, `IR`=ROM[16]. No stale PC ever appears.
- **Simultaneous redirect:** assert `branch` (0x80) and `jump` (0x20) in the same cycle → first valid `PC`=0x80. Also assert `jump`=0x22 alone → `PC`=0x20 (low bits dropped).
- **Wrap-around:** `IMEM_AW`=2, `RESET_PC`=8 → `PC` sequence 8, 12, 16, 20 with `IR` = ROM[2], ROM[3], ROM[0], ROM[1].
- **Reset mid-run:** assert `rst` with a full FIFO and a fetch in flight → after the edge, `count`=0 and `if_valid`=0; after release, fetching restarts at `RESET_PC`.
